// File: rtl/cbfp_index_restore.sv
// Re-expands 11-bit block-floating-point mantissas to 23-bit fixed point using per-beat shift indices.
// Fixed 2-cycle latency, no backpressure; index vectors queue in a small FIFO, with overflow/underflow flagged sticky.
module cbfp_index_restore #(
   parameter int cnt_size   = 5,
   parameter int array_size = 16,
   parameter int array_num  = 4,
   parameter int din_size   = 11,
   parameter int dout_size  = 23,
   parameter int shift_base = 12,
   parameter int idx_depth  = 4
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        valid_in,
   input  logic signed [din_size-1:0]  din [0:array_size-1],
   input  logic                        idx_valid,
   input  logic [cnt_size-1:0]         idx_in [0:array_num-1],
   output logic signed [dout_size-1:0] dout [0:array_size-1],
   output logic                        valid_out,
   output logic                        idx_ovf,
   output logic                        idx_udf
);
   localparam int beat_w = (array_num > 1) ? $clog2(array_num) : 1;
   localparam int ptr_w  = (idx_depth > 1) ? $clog2(idx_depth) : 1;
   localparam int occ_w  = $clog2(idx_depth + 1);
   localparam logic [cnt_size-1:0] base_c    = cnt_size'(shift_base);
   localparam logic [beat_w-1:0]   last_beat = beat_w'(array_num - 1);
   localparam logic [ptr_w-1:0]    last_ptr  = ptr_w'(idx_depth - 1);
   localparam logic [occ_w-1:0]    full_occ  = occ_w'(idx_depth);

   typedef logic [array_num-1:0][cnt_size-1:0] ivec_t;

   logic [beat_w-1:0]          beat_q, beat_d;
   logic [ptr_w-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [occ_w-1:0]           occ_q, occ_d;
   ivec_t                      mem_q [idx_depth];
   ivec_t                      mem_d [idx_depth];
   ivec_t                      cur_idx_q, cur_idx_d;
   logic                       s1_vld_q, s1_vld_d;
   logic signed [din_size-1:0] s1_din_q [array_size];
   logic signed [din_size-1:0] s1_din_d [array_size];
   logic [cnt_size-1:0]        s1_shift_q, s1_shift_d;
   logic                       vld_q, vld_d;
   logic signed [dout_size-1:0] dout_q [array_size];
   logic signed [dout_size-1:0] dout_d [array_size];
   logic                       ovf_q, ovf_d, udf_q, udf_d;

   logic  beat0, fifo_empty, fifo_full, pop, bypass, push;
   ivec_t idx_vec, head_vec;
   logic [cnt_size-1:0] shift_sel;

   function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
      return (p == last_ptr) ? '0 : p + 1'b1;
   endfunction

   // Index below base scales up, above base scales down (arithmetic, floors toward -inf).
   function automatic logic signed [dout_size-1:0] restore(input logic signed [din_size-1:0] m,
                                                          input logic [cnt_size-1:0] s);
      logic signed [dout_size-1:0] ext;
      ext = {{(dout_size-din_size){m[din_size-1]}}, m};
      if (s <= base_c) return ext <<< (base_c - s);
      else             return ext >>> (s - base_c);
   endfunction

   always_comb begin
      idx_vec = '0;
      for (int k = 0; k < array_num; k++) idx_vec[k] = idx_in[k];

      beat0      = valid_in && (beat_q == '0);
      fifo_empty = (occ_q == '0);
      fifo_full  = (occ_q == full_occ);
      pop        = beat0 && !fifo_empty;
      bypass     = beat0 && fifo_empty && idx_valid;
      push       = idx_valid && !bypass && (!fifo_full || pop);

      beat_d    = beat_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      occ_d     = occ_q;
      mem_d     = mem_q;
      cur_idx_d = cur_idx_q;
      shift_sel = base_c;

      if (valid_in) beat_d = (beat_q == last_beat) ? '0 : beat_q + 1'b1;

      head_vec = pop ? mem_q[rd_ptr_q] : (bypass ? idx_vec : {array_num{base_c}});
      if (beat0) begin
         cur_idx_d = head_vec;
         shift_sel = head_vec[0];
      end else begin
         shift_sel = cur_idx_q[beat_q];
      end

      if (push) begin
         mem_d[wr_ptr_q] = idx_vec;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      occ_d = occ_q + 1'b1;
      else if (pop && !push) occ_d = occ_q - 1'b1;

      ovf_d = ovf_q | (idx_valid && fifo_full && !pop);
      udf_d = udf_q | (beat0 && fifo_empty && !idx_valid);

      s1_vld_d   = valid_in;
      s1_din_d   = s1_din_q;
      s1_shift_d = s1_shift_q;
      if (valid_in) begin
         s1_din_d   = din;
         s1_shift_d = shift_sel;
      end

      vld_d  = s1_vld_q;
      dout_d = dout_q;
      if (s1_vld_q) begin
         for (int i = 0; i < array_size; i++) dout_d[i] = restore(s1_din_q[i], s1_shift_q);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         mem_q      <= '{default: '0};
         cur_idx_q  <= {array_num{base_c}};
         s1_vld_q   <= 1'b0;
         s1_din_q   <= '{default: '0};
         s1_shift_q <= base_c;
         vld_q      <= 1'b0;
         dout_q     <= '{default: '0};
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         beat_q     <= beat_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         mem_q      <= mem_d;
         cur_idx_q  <= cur_idx_d;
         s1_vld_q   <= s1_vld_d;
         s1_din_q   <= s1_din_d;
         s1_shift_q <= s1_shift_d;
         vld_q      <= vld_d;
         dout_q     <= dout_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
      end
   end

   always_comb begin
      for (int i = 0; i < array_size; i++) dout[i] = dout_q[i];
   end
   assign valid_out = vld_q;
   assign idx_ovf   = ovf_q;
   assign idx_udf   = udf_q;

endmodule

// File: tb/tb_cbfp_index_restore.sv
// Bench for cbfp_index_restore: directed cases plus random traffic against a queue-based reference model.
module tb_cbfp_index_restore;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rstn, valid_in, idx_valid;
   logic signed [10:0] din [0:15];
   logic [4:0]         idx_in [0:3];
   logic signed [22:0] dout [0:15];
   logic               valid_out, idx_ovf, idx_udf;

   cbfp_index_restore dut (
      .clk(clk), .rstn(rstn), .valid_in(valid_in), .din(din),
      .idx_valid(idx_valid), .idx_in(idx_in), .dout(dout),
      .valid_out(valid_out), .idx_ovf(idx_ovf), .idx_udf(idx_udf)
   );

   int n_checks = 0;
   int n_errors = 0;
   int edge_n   = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   typedef logic [3:0][4:0]   ivec_t;
   typedef logic [15:0][22:0] beat_t;

   ivec_t m_q[$];
   ivec_t m_cur;
   int    m_beat;
   bit    m_ovf, m_udf;
   int    exp_due[$];
   beat_t exp_dat[$];
   beat_t last_exp;

   function automatic int restore_ref(int x, int s);
      if (s <= 12) return x * (1 << (12 - s));
      else begin
         int d = 1 << (s - 12);
         int q = x / d;
         if ((x % d) != 0 && x < 0) q = q - 1;
         return q;
      end
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_cur  = {4{5'd12}};
      m_beat = 0;
      m_ovf  = 0;
      m_udf  = 0;
      exp_due.delete();
      exp_dat.delete();
      last_exp = '0;
   endtask

   // Applies the block's rules for the inputs present at the upcoming clock edge.
   task automatic model_edge();
      ivec_t iv_vec;
      beat_t b;
      int    s;
      bit    byp;
      byp = 0;
      for (int k = 0; k < 4; k++) iv_vec[k] = idx_in[k];
      if (valid_in) begin
         if (m_beat == 0) begin
            if (m_q.size() > 0) m_cur = m_q.pop_front();
            else if (idx_valid) begin m_cur = iv_vec; byp = 1; end
            else begin m_cur = {4{5'd12}}; m_udf = 1; end
         end
         s = int'(m_cur[m_beat]);
         for (int i = 0; i < 16; i++) b[i] = 23'(restore_ref(int'(din[i]), s));
         exp_due.push_back(edge_n + 2);
         exp_dat.push_back(b);
         m_beat = (m_beat + 1) % 4;
      end
      if (idx_valid && !byp) begin
         if (m_q.size() < 4) m_q.push_back(iv_vec);
         else m_ovf = 1;
      end
   endtask

   task automatic check_outputs(input string ctx);
      bit ev;
      ev = (exp_due.size() > 0) && (exp_due[0] == edge_n);
      check({ctx, ":valid_out"}, valid_out, ev);
      if (ev) begin
         last_exp = exp_dat.pop_front();
         void'(exp_due.pop_front());
      end
      for (int i = 0; i < 16; i++)
         check($sformatf("%s:dout[%0d]", ctx, i), dout[i], $signed(last_exp[i]));
      check({ctx, ":idx_ovf"}, idx_ovf, m_ovf);
      check({ctx, ":idx_udf"}, idx_udf, m_udf);
   endtask

   task automatic tick(input bit v, input bit iv, input string ctx);
      valid_in  = v;
      idx_valid = iv;
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_outputs(ctx);
   endtask

   task automatic set_din_all(input int val);
      for (int i = 0; i < 16; i++) din[i] = 11'(val);
   endtask

   task automatic set_din_rand();
      for (int i = 0; i < 16; i++) din[i] = 11'($urandom);
   endtask

   task automatic set_idx(input int a, input int b, input int c, input int d);
      idx_in[0] = 5'(a); idx_in[1] = 5'(b); idx_in[2] = 5'(c); idx_in[3] = 5'(d);
   endtask

   task automatic set_idx_rand();
      for (int k = 0; k < 4; k++) idx_in[k] = 5'($urandom);
   endtask

   task automatic do_reset(input string ctx);
      rstn = 1'b0; valid_in = 1'b0; idx_valid = 1'b0;
      #1;
      check({ctx, ":valid_out"}, valid_out, 0);
      check({ctx, ":idx_ovf"}, idx_ovf, 0);
      check({ctx, ":idx_udf"}, idx_udf, 0);
      for (int i = 0; i < 16; i++) check($sformatf("%s:dout[%0d]", ctx, i), dout[i], 0);
      model_reset();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      rstn = 1'b1; valid_in = 1'b0; idx_valid = 1'b0;
      set_din_all(0); set_idx(12, 12, 12, 12);
      model_reset();
      #2;
      do_reset("reset");

      // Unity scale.
      set_idx(12, 12, 12, 12); tick(0, 1, "unity_push");
      set_din_all(5);
      repeat (4) tick(1, 0, "unity_beat");
      repeat (3) tick(0, 0, "unity_drain");

      // Mixed indices with known results.
      set_idx(10, 14, 0, 31); tick(0, 1, "mix_push");
      set_din_all(-3);   tick(1, 0, "mix_b0");
      tick(1, 0, "mix_b1");
      check("mix_b0_const", dout[0], -12);
      set_din_all(1023); tick(1, 0, "mix_b2");
      check("mix_b1_const", dout[0], -1);
      set_din_all(-3);   tick(1, 0, "mix_b3");
      check("mix_b2_const", dout[0], 4190208);
      tick(0, 0, "mix_drain");
      check("mix_b3_const", dout[0], -1);
      repeat (2) tick(0, 0, "mix_drain");

      // Fill the FIFO, overflow it, then push alongside a pop while full.
      for (int j = 0; j < 4; j++) begin set_idx_rand(); tick(0, 1, "ovf_fill"); end
      set_idx_rand(); tick(0, 1, "ovf_drop");
      check("ovf_flag", idx_ovf, 1);
      set_idx_rand(); set_din_rand(); tick(1, 1, "ovf_popush");
      for (int j = 0; j < 3; j++) begin set_din_rand(); tick(1, 0, "ovf_beat"); end
      for (int blk = 0; blk < 8 && m_q.size() > 0; blk++)
         for (int j = 0; j < 4; j++) begin set_din_rand(); tick(1, 0, "ovf_drainblk"); end
      repeat (3) tick(0, 0, "ovf_drain");

      // Bypass: empty FIFO with index arriving on beat 0.
      set_idx(11, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      set_din_all(7); tick(1, 1, "byp_b0");
      set_din_rand(); tick(1, 0, "byp_b1");
      check("byp_const", dout[0], 14);
      set_din_rand(); tick(1, 0, "byp_b2");
      set_din_rand(); tick(1, 0, "byp_b3");
      repeat (3) tick(0, 0, "byp_drain");

      // Underflow: FIFO must still be empty after the bypass.
      set_din_all(-100);
      repeat (4) tick(1, 0, "udf_beat");
      repeat (2) tick(0, 0, "udf_drain");
      check("udf_const", dout[0], -100);
      check("udf_flag", idx_udf, 1);

      // Reset after beat 1 with two vectors still queued.
      for (int j = 0; j < 3; j++) begin set_idx_rand(); tick(0, 1, "mrst_push"); end
      set_din_rand(); tick(1, 0, "mrst_b0");
      set_din_rand(); tick(1, 0, "mrst_b1");
      do_reset("mrst");
      set_din_all(9);
      repeat (4) tick(1, 0, "post_rst_beat");
      repeat (2) tick(0, 0, "post_rst_drain");
      check("post_rst_const", dout[0], 9);

      // Random traffic with gaps, early indices, overflows and underflows.
      for (int c = 0; c < 800; c++) begin
         set_din_rand(); set_idx_rand();
         if ($urandom_range(0, 3) == 0) idx_in[0] = 5'($urandom_range(8, 16));
         tick($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, "rand");
      end
      repeat (3) tick(0, 0, "rand_drain");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
